// File: rtl/sdram_port_pkg.sv
// Shared types and address-window constants for the SDRAM FIFO-port switch.
// Windows are in SDRAM words: camera frame, neural-network buffer, VGA frame.
package sdram_port_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_LOAD
    } port_state_e;

    localparam int unsigned CAM_BASE = 0;
    localparam int unsigned CAM_MAX  = 320 * 240;
    localparam int unsigned NN_BASE  = 22'h100000;
    localparam int unsigned NN_MAX   = 22'h100000 + 320 * 240;
    localparam int unsigned VGA_BASE = 20'h13880;
    localparam int unsigned VGA_MAX  = 20'h13880 + 50000;

endpackage

// File: rtl/sdram_port_drain_ctr.sv
// Idle-run and timeout counters used while the current owner drains.
// Both counters sit at zero outside DRAIN, so every DRAIN starts from a clean count.
module sdram_port_drain_ctr #(
    parameter int IDLE_CYCLES   = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic owner_en_i,
    output logic idle_done_o,
    output logic timeout_o
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;

    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        idle_d = '0;
        tmo_d  = '0;
        if (active_i) begin
            idle_d = owner_en_i ? '0 : idle_q + IW'(1);
            tmo_d  = tmo_q + TW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idle_q <= '0;
            tmo_q  <= '0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    // Flags fire in the drain cycle that completes the idle run / the timeout window.
    assign idle_done_o = active_i && !owner_en_i && (idle_q == IW'(IDLE_CYCLES - 1));
    assign timeout_o   = active_i && (tmo_q == TW'(DRAIN_TIMEOUT - 1));

endmodule

// File: rtl/sdram_port_switch.sv
// Registered owner switch for one Sdram_Control_4Port FIFO port group:
// drains the current client, pulses LOAD with the new window, then grants.
module sdram_port_switch
    import sdram_port_pkg::*;
#(
    parameter int N_SRC         = 2,
    parameter int SW            = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter int DW            = 16,
    parameter int AW            = 23,
    parameter int IDLE_CYCLES   = 4,
    parameter int LOAD_CYCLES   = 2,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [SW-1:0]       iSEL,
    input  logic [N_SRC*DW-1:0] iSRC_DATA,
    input  logic [N_SRC-1:0]    iSRC_EN,
    input  logic [N_SRC*AW-1:0] iSRC_BASE,
    input  logic [N_SRC*AW-1:0] iSRC_MAX,
    output logic [DW-1:0]       oDATA,
    output logic                oEN,
    output logic [AW-1:0]       oADDR,
    output logic [AW-1:0]       oMAX_ADDR,
    output logic                oLOAD,
    output logic [N_SRC-1:0]    oGNT,
    output logic [SW-1:0]       oOWNER,
    output logic                oBUSY,
    output logic [7:0]          oFORCED
);

    localparam int LW = $clog2(LOAD_CYCLES + 1);

    port_state_e   state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] max_q, max_d;
    logic          en_q, en_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    forced_q, forced_d;

    logic          sel_valid;
    logic          owner_en;
    logic [DW-1:0] owner_data;
    logic          enter_load;
    logic          idle_done;
    logic          timeout;

    assign sel_valid  = int'(iSEL) < N_SRC;
    assign owner_en   = iSRC_EN[owner_q];
    assign owner_data = iSRC_DATA[int'(owner_q)*DW +: DW];

    sdram_port_drain_ctr #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_drain_ctr (
        .clk_i      (iCLK),
        .rst_ni     (iRST_N),
        .active_i   (state_q == S_DRAIN),
        .owner_en_i (owner_en),
        .idle_done_o(idle_done),
        .timeout_o  (timeout)
    );

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        load_cnt_d = load_cnt_q;
        addr_d     = addr_q;
        max_d      = max_q;
        forced_d   = forced_q;
        enter_load = 1'b0;

        case (state_q)
            S_RUN: begin
                if (sel_valid && (iSEL != owner_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A withdrawn or invalid request cancels the switch even on the completing cycle.
                if (!sel_valid || (iSEL == owner_q)) begin
                    state_d = S_RUN;
                end else if (idle_done) begin
                    enter_load = 1'b1;
                end else if (timeout) begin
                    enter_load = 1'b1;
                    if (forced_q != 8'hFF) forced_d = forced_q + 8'd1;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == LW'(LOAD_CYCLES - 1)) state_d = S_RUN;
                else load_cnt_d = load_cnt_q + LW'(1);
            end
            default: state_d = S_LOAD;
        endcase

        if (enter_load) begin
            state_d    = S_LOAD;
            owner_d    = iSEL;
            load_cnt_d = '0;
            addr_d     = iSRC_BASE[int'(iSEL)*AW +: AW];
            max_d      = iSRC_MAX[int'(iSEL)*AW +: AW];
        end

        // Pass-through keeps running in DRAIN so in-flight words complete; LOAD blanks the enable.
        en_d   = (state_q != S_LOAD) && !enter_load && owner_en;
        data_d = (state_q != S_LOAD) ? owner_data : data_q;
    end

    // NOTE: reset is synchronous; the window registers reload source 0's window while held in reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= S_LOAD;
            owner_q    <= '0;
            load_cnt_q <= '0;
            addr_q     <= iSRC_BASE[AW-1:0];
            max_q      <= iSRC_MAX[AW-1:0];
            en_q       <= 1'b0;
            data_q     <= '0;
            forced_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            load_cnt_q <= load_cnt_d;
            addr_q     <= addr_d;
            max_q      <= max_d;
            en_q       <= en_d;
            data_q     <= data_d;
            forced_q   <= forced_d;
        end
    end

    assign oDATA     = data_q;
    assign oEN       = en_q;
    assign oADDR     = addr_q;
    assign oMAX_ADDR = max_q;
    assign oLOAD     = (state_q == S_LOAD);
    assign oBUSY     = (state_q != S_RUN);
    assign oGNT      = (state_q == S_RUN) ? (N_SRC'(1) << owner_q) : '0;
    assign oOWNER    = owner_q;
    assign oFORCED   = forced_q;

endmodule

// File: doc/sdram_port_switch.md
Name: sdram_port_switch

Overview:
- Parametrised, registered switch that hands one Sdram_Control_4Port FIFO port (write or read side) between N_SRC clients, e.g. camera/VGA vs. HPS neural-network traffic.
- It replaces the free-running combinational port muxes with a safe switchover:
  - drain the current owner;
  - pulse the port LOAD with the new owner's address window;
  - grant the new owner.
- It sits between the clients and one WRx/RDx port group; one instance per port.

Parameters:
- N_SRC, 2, number of client sources (2..8).
- SW, 1, select width; clog2(N_SRC), minimum 1.
- DW, 16, data width.
- AW, 23, SDRAM word-address width.
- IDLE_CYCLES, 4, consecutive idle cycles of the owner's enable required before switching.
- LOAD_CYCLES, 2, length of the oLOAD pulse in cycles.
- DRAIN_TIMEOUT, 1024, maximum DRAIN cycles before a forced switch.

Ports:
- iCLK  in  1  port clock; all clients are synchronous to it (any CDC is done outside).
- iRST_N  in  1  synchronous, active-low reset.
- iSEL  in  SW  requested owner index.
- iSRC_DATA  in  N_SRC*DW  client write data, packed, source 0 in the LSBs.
- iSRC_EN  in  N_SRC  client write/read enables.
- iSRC_BASE  in  N_SRC*AW  client start addresses.
- iSRC_MAX  in  N_SRC*AW  client max addresses.
- oDATA  out  DW  to WRx_DATA.
- oEN  out  1  to WRx/RDx enable.
- oADDR  out  AW  to port ADDR.
- oMAX_ADDR  out  AW  to port MAX_ADDR.
- oLOAD  out  1  to port LOAD.
- oGNT  out  N_SRC  one-hot grant; a client may drive its enable only while granted.
- oOWNER  out  SW  current owner index.
- oBUSY  out  1  high in DRAIN or LOAD.
- oFORCED  out  8  saturating count of timeout-forced switches.

Behaviour:
- Reset (iRST_N low at a rising edge of iCLK), all registers:
  - owner=0, state=LOAD, load counter=0;
  - oADDR/oMAX_ADDR = source 0 base/max;
  - oLOAD=1, oEN=0, oDATA=0, oGNT=0, oBUSY=1, oFORCED=0.
  - After release, oLOAD stays high for LOAD_CYCLES cycles, then the FSM enters RUN.
- RUN:
  - oGNT=onehot(owner); oBUSY=0.
  - oDATA/oEN = owner's data/enable, registered (1-cycle latency); non-owner enables are ignored.
  - If iSEL != owner and iSEL < N_SRC: go to DRAIN, clear the idle and timeout counters.
  - If iSEL >= N_SRC, the request is ignored.
- DRAIN:
  - oGNT=0; the owner's data and enable are still passed through, so in-flight words complete.
  - Idle counter increments while the owner's enable is 0 and resets to 0 whenever it is 1.
  - Timeout counter increments every cycle.
  - Idle counter == IDLE_CYCLES: target=iSEL (sampled that cycle), go to LOAD.
  - Timeout counter == DRAIN_TIMEOUT-1: target=iSEL, oFORCED++ (saturates at 255), go to LOAD. From the next cycle oEN is forced to 0.
  - If iSEL returns to owner (or goes out of range) before either condition: go back to RUN with no LOAD and no change to oADDR.
- LOAD:
  - On entry: owner<=target, oADDR/oMAX_ADDR <= target base/max, oEN=0, oLOAD=1.
  - Hold for LOAD_CYCLES cycles, then go to RUN.
  - iSEL changes during LOAD are not acted on until RUN; the next cycle in RUN compares again, so back-to-back switches each take their own full DRAIN and LOAD.
- Address window: BASE/MAX are sampled only on LOAD entry; changes during RUN take effect only at the next switch.
- Width rule: packed slice i occupies [i*DW +: DW] and [i*AW +: AW].
- Switch latency from an iSEL change with an already idle owner: IDLE_CYCLES+1 cycles to LOAD entry, then LOAD_CYCLES more to grant.
- Reset mid-operation, in any state, returns to the reset state above. Sources' in-flight words are dropped.

Decomposition:
- Shared package sdram_port_pkg:
  - FSM state enum (S_RUN, S_DRAIN, S_LOAD);
  - localparams for the camera, NN and VGA address windows: 0, 320*240, 22'h100000, 22'h100000+320*240, 20'h13880, 20'h13880+50000.
- One natural sub-module: sdram_port_drain_ctr, which holds the idle counter and timeout counter and outputs the idle-done and timeout flags.
- Everything else (FSM, pass-through mux) stays in the top.

Test Plan:
- Reset with N_SRC=2, BASE0=0, MAX0=76800: oLOAD high exactly 2 cycles after release, oADDR=0, oMAX_ADDR=76800, then oGNT=2'b01.
- In RUN with owner 0, set iSRC_EN[0]=1 and iSRC_DATA[0]=16'hA5A5: one cycle later oEN=1 and oDATA=A5A5. iSRC_EN[1]=1 with no grant leaves the outputs unchanged.
- Set iSEL=1 with source 0 idle, BASE1=0x13880: DRAIN 4 cycles, then oLOAD high 2 cycles with oADDR=0x13880 and oMAX_ADDR=0x13880+50000. oGNT=2'b10, oFORCED=0.
- Set iSEL=1 while source 0 holds enable high continuously: forced switch after 1024 cycles, oFORCED=1, oEN=0 from the cycle after the timeout.
- Set iSEL=1 then back to 0 after 2 cycles in DRAIN: return to RUN, no oLOAD pulse, oADDR unchanged. Also drive iSEL=3 with N_SRC=3 (out of range): no state change.
- Pull iRST_N low for one cycle mid-LOAD on a switch to owner 1: owner=0 and a fresh 2-cycle oLOAD with source-0 addresses. Repeat with oFORCED=255 at saturation and confirm it stays 255 after another forced switch; reset clears it to 0.
